twos_complement_serializer: RTL and testbench

- Downstream stage of the 16-bit bitwise negator.
- Takes the one's-complement word the negator produces and adds 1 bit-serially, LSB first, so the pair yields the full two's-complement negation.
- Uses a single carry flip-flop and a shift register in place of a 16-bit ripple incrementer.
- Valid/ready handshake on both sides; one word in flight at a time.

---
 rtl/twos_complement_serializer_pkg.sv | 18 +
 rtl/twos_complement_serializer_cell.sv | 30 +++
 rtl/twos_complement_serializer.sv | 151 +++++++++++++++
 tb/tb_twos_complement_serializer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/twos_complement_serializer_pkg.sv
// ---------------------------------------------------------------------------
// twos_complement_serializer_pkg
// Shared definitions for the bit-serial two's-complement stage that follows
// the 16-bit bitwise negator.
//   - TCS_DEFAULT_WIDTH : data word width shared with the negator
//   - state_t           : serializer FSM encoding (IDLE / SHIFT / DONE)
// ---------------------------------------------------------------------------
package twos_complement_serializer_pkg;

  localparam int TCS_DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage : twos_complement_serializer_pkg

// File: rtl/twos_complement_serializer_cell.sv
// ---------------------------------------------------------------------------
// serial_half_adder_cell
// One-bit half adder used once per shift to add the running carry into the
// current LSB. Built from nand primitives in the same gate-level style as the
// negator's notgate.
// Ports:
//   a    in   data bit (shift register LSB)
//   cin  in   running carry
//   sum  out  a ^ cin
//   cout out  a & cin
// ---------------------------------------------------------------------------
module serial_half_adder_cell (
  input  logic a,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic nand_ab_s;
  logic nand_a_s;
  logic nand_c_s;

  // Classic four-nand XOR; the shared first nand also yields the AND.
  nand g_nab (nand_ab_s, a, cin);
  nand g_na  (nand_a_s, a, nand_ab_s);
  nand g_nc  (nand_c_s, cin, nand_ab_s);
  nand g_sum (sum, nand_a_s, nand_c_s);
  nand g_co  (cout, nand_ab_s, nand_ab_s);

endmodule : serial_half_adder_cell

// File: rtl/twos_complement_serializer.sv
// ---------------------------------------------------------------------------
// twos_complement_serializer
// Adds 1 to the one's-complement word from the negator, one bit per cycle,
// LSB first, so negator + serializer give the full two's-complement negation.
// One word in flight; valid/ready on both sides.
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   upstream word available
//   in_ready   out  block can accept a word (IDLE and not in reset)
//   in_data    in   one's-complement word
//   out_valid  out  result available (registered)
//   out_ready  in   downstream accepts result
//   out_data   out  in_data + 1 mod 2**WIDTH (registered)
//   out_carry  out  final carry; set only for an all-ones input (registered)
//   out_ovf    out  signed overflow; set only for 0111..1 input (registered)
// ---------------------------------------------------------------------------
module twos_complement_serializer
  import twos_complement_serializer_pkg::*;
#(
  parameter int WIDTH = TCS_DEFAULT_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_ovf
);

  localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] sr_r;
  logic             carry_r;
  logic             ovf_r;
  logic [CNT_W-1:0] cnt_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic             out_carry_r;
  logic             out_ovf_r;
  logic             sum_s;
  logic             cout_s;
  logic             last_shift_s;

  serial_half_adder_cell u_cell (
    .a    (sr_r[0]),
    .cin  (carry_r),
    .sum  (sum_s),
    .cout (cout_s)
  );

  // Ready only from the state register, and never while reset is held.
  assign in_ready     = rst_n & (state_r == ST_IDLE);
  assign last_shift_s = (cnt_r == LAST_CNT);

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_carry = out_carry_r;
  assign out_ovf   = out_ovf_r;

  // Next-state decode for the IDLE -> SHIFT -> DONE sequence.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_next_s = ST_SHIFT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (last_shift_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers; reset discards any word in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      sr_r        <= '0;
      carry_r     <= 1'b0;
      ovf_r       <= 1'b0;
      cnt_r       <= CNT_ZERO;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_carry_r <= 1'b0;
      out_ovf_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            sr_r    <= in_data;
            carry_r <= 1'b1;
            cnt_r   <= CNT_ZERO;
            ovf_r   <= (in_data == MAX_POS);
          end
        end
        ST_SHIFT: begin
          // Sum bit enters at the MSB so after WIDTH shifts the word is in order.
          sr_r    <= {sum_s, sr_r[WIDTH-1:1]};
          carry_r <= cout_s;
          if (last_shift_s) begin
            cnt_r       <= CNT_ZERO;
            out_valid_r <= 1'b1;
            out_data_r  <= {sum_s, sr_r[WIDTH-1:1]};
            out_carry_r <= cout_s;
            out_ovf_r   <= ovf_r;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule : twos_complement_serializer

// File: tb/tb_twos_complement_serializer.sv
// ---------------------------------------------------------------------------
// tb_twos_complement_serializer
// Directed self-checking bench for the bit-serial two's-complement stage.
// ---------------------------------------------------------------------------
module tb_twos_complement_serializer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_carry;
  logic        out_ovf;

  int errors;
  int checks;

  twos_complement_serializer #(.WIDTH(16), .CNT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word and complete the input handshake (edge E0).
  task automatic accept_word(input logic [15:0] d);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    check("ready_low_in_shift", {31'd0, in_ready}, 32'd0);
  endtask

  // Edges E1..E16; out_valid must appear exactly after E16.
  task automatic wait_result(input bit perturb);
    logic early;
    early = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (out_valid) early = 1'b1;
      if (perturb) begin
        in_data  = 16'($urandom);
        in_valid = 1'($urandom);
      end
    end
    tick();
    in_valid = 1'b0;
    check("valid_early", {31'd0, early}, 32'd0);
    check("valid_latency", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [15:0] d,
                              input logic c, input logic o);
    check({tag, "_data"}, {16'd0, out_data}, {16'd0, d});
    check({tag, "_carry"}, {31'd0, out_carry}, {31'd0, c});
    check({tag, "_ovf"}, {31'd0, out_ovf}, {31'd0, o});
  endtask

  // Output handshake edge; block returns to IDLE afterwards.
  task automatic drain();
    out_ready = 1'b1;
    tick();
    check("valid_cleared", {31'd0, out_valid}, 32'd0);
    check("ready_after_done", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_word(input string tag, input logic [15:0] din, input logic [15:0] d,
                          input logic c, input logic o, input bit perturb);
    accept_word(din);
    wait_result(perturb);
    check_result(tag, d, c, o);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_valid;
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    out_ready = 1'b1;

    // Reset state
    tick(); tick(); tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_result("rst", 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Basic arithmetic and boundary cases
    run_word("fffe", 16'hFFFE, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    run_word("ffff", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_word("7fff", 16'h7FFF, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_word("0000", 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0);

    // Backpressure with a pending upstream word
    out_ready = 1'b0;
    accept_word(16'h1234);
    wait_result(1'b0);
    in_valid = 1'b1;
    in_data  = 16'hAAAA;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check_result("bp", 16'h1235, 1'b0, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", {31'd0, out_valid}, 32'd0);
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_held_accepted", {31'd0, in_ready}, 32'd0);
    wait_result(1'b0);
    check_result("aaaa", 16'hAAAB, 1'b0, 1'b0);
    drain();

    // Reset in the middle of SHIFT (cnt = 8)
    accept_word(16'h5555);
    for (int i = 0; i < 8; i++) tick();
    rst_n = 1'b0;
    tick(); tick();
    check("midrst_ready", {31'd0, in_ready}, 32'd0);
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("midrst_ready_after", {31'd0, in_ready}, 32'd1);
    saw_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) saw_valid = 1'b1;
    end
    check("midrst_no_pulse", {31'd0, saw_valid}, 32'd0);
    run_word("fff9", 16'hFFF9, 16'hFFFA, 1'b0, 1'b0, 1'b0);

    // Input perturbation during SHIFT
    run_word("perturb", 16'h0F0F, 16'h0F10, 1'b0, 1'b0, 1'b1);

    // Chain with the negator: in_data = ~original
    run_word("neg_0001", 16'hFFFE, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    run_word("neg_8000", 16'h7FFF, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_word("neg_0000", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_word("neg_1234", 16'hEDCB, 16'hEDCC, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_twos_complement_serializer
